// File: rtl/score_controller.sv
// Running-man session controller: start/pause/game-over sequencing,
// 6-digit BCD score accumulator with saturation and high-score latch.
module score_controller #(
  parameter int TICK_DIV  = 50000000,
  parameter int DIV_W     = 26,
  parameter int BONUS_PTS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        bonus,
  input  logic        gameover,
  output logic [23:0] score_bcd,
  output logic [23:0] hiscore_bcd,
  output logic [1:0]  state,
  output logic        running,
  output logic        new_record
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [23:0] BONUS_BCD = {
    16'h0000,
    4'(BONUS_PTS / 10),
    4'(BONUS_PTS % 10)
  };

  state_t            st;
  logic [DIV_W-1:0]  div;
  logic [23:0]       score_q;
  logic [23:0]       hi_q;
  logic              rec_q;
  logic              start_d;
  logic              pause_d;
  logic              bonus_d;

  logic              start_p;
  logic              pause_p;
  logic              bonus_p;
  logic              adv;
  logic              tick;
  logic [23:0]       inc_bcd;
  logic [24:0]       inc_sum;
  logic [24:0]       sum;
  logic [23:0]       score_nx;
  logic              is_rec;

  function automatic logic [24:0] bcd_add(
    input logic [23:0] a,
    input logic [23:0] b
  );
    logic [4:0]  s;
    logic        c;
    logic [23:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      s = {1'b0, a[i*4 +: 4]}
        + {1'b0, b[i*4 +: 4]}
        + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  assign start_p = start & ~start_d;
  assign pause_p = pause & ~pause_d;
  assign bonus_p = bonus & ~bonus_d;

  // a pausing or ending cycle neither counts nor scores
  assign adv  = (st == RUN) && !gameover && !pause_p;
  assign tick = adv && (div == DIV_MAX);

  always_comb begin
    inc_bcd  = '0;
    inc_sum  = bcd_add({23'b0, tick},
                       (adv && bonus_p) ? BONUS_BCD : 24'h0);
    inc_bcd  = inc_sum[23:0];
    sum      = bcd_add(score_q, inc_bcd);
    score_nx = sum[24] ? 24'h999999 : sum[23:0];
    is_rec   = score_q > hi_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      div     <= '0;
      score_q <= '0;
      hi_q    <= '0;
      rec_q   <= 1'b0;
      start_d <= 1'b0;
      pause_d <= 1'b0;
      bonus_d <= 1'b0;
    end else begin
      start_d <= start;
      pause_d <= pause;
      bonus_d <= bonus;
      unique case (st)
        IDLE, OVER: begin
          if (start_p) begin
            st      <= RUN;
            score_q <= '0;
            div     <= '0;
            rec_q   <= 1'b0;
          end
        end
        RUN, PAUSE: begin
          if (gameover) begin
            st <= OVER;
            if (is_rec) begin
              hi_q  <= score_q;
              rec_q <= 1'b1;
            end
          end else if (pause_p) begin
            st <= (st == RUN) ? PAUSE : RUN;
          end else if (st == RUN) begin
            div     <= tick ? '0 : div + DIV_W'(1);
            score_q <= score_nx;
          end
        end
      endcase
    end
  end

  assign score_bcd   = score_q;
  assign hiscore_bcd = hi_q;
  assign state       = st;
  assign running     = (st == RUN);
  assign new_record  = rec_q;

endmodule

// File: tb/tb_score_controller.sv
// Scoreboard bench for score_controller: game flow on a TICK_DIV=4 unit,
// saturation on a fast TICK_DIV=2 / BONUS_PTS=99 unit.
module tb_score_controller;

  logic        clk;
  logic        reset;
  logic        start, pause, bonus, gameover;
  logic [23:0] score_bcd, hiscore_bcd;
  logic [1:0]  state;
  logic        running, new_record;

  logic        start2, pause2, bonus2, gameover2;
  logic [23:0] score2, hi2;
  logic [1:0]  state2;
  logic        running2, rec2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t q[$];

  score_controller #(
    .TICK_DIV(4), .DIV_W(26), .BONUS_PTS(10)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .pause(pause),
    .bonus(bonus), .gameover(gameover),
    .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd),
    .state(state), .running(running),
    .new_record(new_record)
  );

  score_controller #(
    .TICK_DIV(2), .DIV_W(26), .BONUS_PTS(99)
  ) dut2 (
    .clk(clk), .reset(reset),
    .start(start2), .pause(pause2),
    .bonus(bonus2), .gameover(gameover2),
    .score_bcd(score2), .hiscore_bcd(hi2),
    .state(state2), .running(running2),
    .new_record(rec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    q.push_back(it);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    sb_t it;
    if (q.size() == 0) begin
      it.tag = "sb_underflow";
      it.exp = 32'hdead_beef;
    end else begin
      it = q.pop_front();
    end
    chk(it.tag, got, it.exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    start = 0; pause = 0; bonus = 0; gameover = 0;
    start2 = 0; pause2 = 0; bonus2 = 0; gameover2 = 0;
    step(2);
    push("rst_state", 0); push("rst_score", 0);
    push("rst_hi", 0); push("rst_run", 0); push("rst_rec", 0);
    pop_chk(32'(state)); pop_chk(32'(score_bcd));
    pop_chk(32'(hiscore_bcd)); pop_chk(32'(running));
    pop_chk(32'(new_record));
    reset = 1'b1;
    step(1);

    start = 1;
    push("start_state", 1);
    step(1);
    pop_chk(32'(state));
    start = 0;
    push("run12", 'h3); push("hi0", 0);
    step(12);
    pop_chk(32'(score_bcd)); pop_chk(32'(hiscore_bcd));

    step(3);
    bonus = 1;
    push("tick_bonus", 'h14);
    step(1);
    pop_chk(32'(score_bcd));
    push("bonus_held", 'h15);
    step(4);
    pop_chk(32'(score_bcd));
    bonus = 0;

    step(2);
    pause = 1;
    push("pause_state", 2); push("pause_run", 0);
    step(1);
    pop_chk(32'(state)); pop_chk(32'(running));
    pause = 0;
    bonus = 1;
    step(1);
    bonus = 0;
    push("pause_frozen", 'h15); push("pause_hold", 2);
    step(19);
    pop_chk(32'(score_bcd)); pop_chk(32'(state));
    pause = 1;
    push("resume", 1);
    step(1);
    pop_chk(32'(state));
    pause = 0;
    push("resume1", 'h15);
    step(1);
    pop_chk(32'(score_bcd));
    push("resume2", 'h16);
    step(1);
    pop_chk(32'(score_bcd));

    gameover = 1; bonus = 1;
    push("go_state", 3); push("go_score", 'h16);
    push("go_hi", 'h16); push("go_rec", 1);
    step(1);
    pop_chk(32'(state)); pop_chk(32'(score_bcd));
    pop_chk(32'(hiscore_bcd)); pop_chk(32'(new_record));
    gameover = 0; bonus = 0;
    step(1);
    bonus = 1;
    step(1);
    bonus = 0; pause = 1;
    step(1);
    pause = 0;
    push("over_frozen", 'h16); push("over_state", 3);
    pop_chk(32'(score_bcd)); pop_chk(32'(state));

    start = 1;
    push("restart_score", 0); push("restart_rec", 0);
    push("restart_hi", 'h16);
    step(1);
    pop_chk(32'(score_bcd)); pop_chk(32'(new_record));
    pop_chk(32'(hiscore_bcd));
    start = 0;
    bonus = 1;
    step(1);
    bonus = 0;
    push("replay", 'h16);
    step(23);
    pop_chk(32'(score_bcd));
    gameover = 1;
    push("eq_hi", 'h16); push("eq_rec", 0); push("eq_state", 3);
    step(1);
    pop_chk(32'(hiscore_bcd)); pop_chk(32'(new_record));
    pop_chk(32'(state));
    gameover = 0;

    start = 1;
    step(1);
    start = 0;
    repeat (9) begin
      bonus = 1;
      step(1);
      bonus = 0;
      step(3);
    end
    push("to99", 'h99);
    pop_chk(32'(score_bcd));
    push("carry100", 'h100);
    step(4);
    pop_chk(32'(score_bcd));
    gameover = 1;
    push("rec_hi", 'h100); push("rec_new", 1);
    step(1);
    pop_chk(32'(hiscore_bcd)); pop_chk(32'(new_record));
    gameover = 0;

    start = 1;
    step(1);
    start = 0;
    repeat (4) begin
      bonus = 1;
      step(1);
      bonus = 0;
      step(1);
    end
    push("pre_rst", 'h42);
    pop_chk(32'(score_bcd));
    #2;
    reset = 0;
    #1;
    push("arst_state", 0); push("arst_score", 0);
    push("arst_hi", 0); push("arst_run", 0); push("arst_rec", 0);
    pop_chk(32'(state)); pop_chk(32'(score_bcd));
    pop_chk(32'(hiscore_bcd)); pop_chk(32'(running));
    pop_chk(32'(new_record));
    step(1);
    reset = 1;
    step(1);
    start = 1;
    push("post_rst_state", 1);
    step(1);
    pop_chk(32'(state));
    start = 0;
    push("post_rst_score", 1);
    step(4);
    pop_chk(32'(score_bcd));

    start2 = 1;
    push("d2_state", 1);
    step(1);
    pop_chk(32'(state2));
    start2 = 0;
    for (int i = 0; i < 9999; i++) begin
      bonus2 = 1;
      step(1);
      bonus2 = 0;
      if (i == 0) push("d2_sum100", 'h100);
      step(1);
      if (i == 0) pop_chk(32'(score2));
    end
    push("d2_999900", 'h999900);
    pop_chk(32'(score2));
    push("d2_999995", 'h999995);
    step(190);
    pop_chk(32'(score2));
    bonus2 = 1;
    push("d2_sat", 'h999999);
    step(1);
    pop_chk(32'(score2));
    bonus2 = 0;
    push("d2_hold", 'h999999); push("d2_run", 1);
    step(10);
    pop_chk(32'(score2)); pop_chk(32'(running2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
